// File: rtl/dpot_scheduler_if.sv
// rtl/dpot_scheduler_if.sv - request/value and Digipot_ctrl signals of dpot_scheduler
interface dpot_scheduler_if;
    logic [2:0] req;
    logic [7:0] val0;
    logic [7:0] val1;
    logic [7:0] val2;
    logic [2:0] ack;
    logic [1:0] mux;
    logic       ctrl;
    logic [7:0] dato;
    logic       busy;
    logic       done;

    modport master (output req, val0, val1, val2,
                    input  ack, mux, ctrl, dato, busy, done);
    modport slave  (input  req, val0, val1, val2,
                    output ack, mux, ctrl, dato, busy, done);
endinterface

// File: rtl/dpot_scheduler.sv
// rtl/dpot_scheduler.sv - round-robin 3-channel digipot write scheduler (optional DPOT_SHADOW_EN)
module dpot_scheduler #(
    parameter int STROBE_CYCLES = 2,
    parameter int XFER_CYCLES   = 48
) (
    input  logic              clk,
    input  logic              rst,
    dpot_scheduler_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, WAIT} state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [1:0] last;
    logic [1:0] c1, c2, pick;
    logic       found;
    logic [7:0] sel_val;
    logic       skip;
    logic       to_strobe;

    // Round-robin search order: last+1, last+2, then last itself.
    always_comb begin
        c1    = (last == 2'd2) ? 2'd0 : last + 2'd1;
        c2    = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        found = 1'b1;
        pick  = c1;
        if (bus.req[c1])        pick = c1;
        else if (bus.req[c2])   pick = c2;
        else if (bus.req[last]) pick = last;
        else                    found = 1'b0;
    end

    always_comb begin
        case (pick)
            2'd0:    sel_val = bus.val0;
            2'd1:    sel_val = bus.val1;
            default: sel_val = bus.val2;
        endcase
    end

    assign to_strobe = (state == SETUP) && (cnt == 8'd0);

`ifdef DPOT_SHADOW_EN
    logic [7:0] shadow [3];
    logic [2:0] valid;

    assign skip = valid[pick] && (shadow[pick] == sel_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= 3'b000;
            shadow[0] <= 8'h00;
            shadow[1] <= 8'h00;
            shadow[2] <= 8'h00;
        end else if (to_strobe) begin
            valid[bus.mux]  <= 1'b1;
            shadow[bus.mux] <= bus.dato;
        end
    end
`else
    assign skip = 1'b0;
`endif

    // SETUP spans the ack cycle plus one settle cycle before the strobe rises.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            last     <= 2'd2;
            bus.ack  <= 3'b000;
            bus.mux  <= 2'd0;
            bus.ctrl <= 1'b0;
            bus.dato <= 8'h00;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.ack  <= 3'b000;
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        bus.ack <= 3'b001 << pick;
                        last    <= pick;
                        if (!skip) begin
                            bus.mux  <= pick;
                            bus.dato <= sel_val;
                            bus.busy <= 1'b1;
                            cnt      <= 8'd1;
                            state    <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (cnt == 8'd0) begin
                        bus.ctrl <= 1'b1;
                        cnt      <= 8'(STROBE_CYCLES - 1);
                        state    <= STROBE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                STROBE: begin
                    if (cnt == 8'd0) begin
                        bus.ctrl <= 1'b0;
                        cnt      <= 8'(XFER_CYCLES - 1);
                        state    <= WAIT;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                WAIT: begin
                    if (cnt == 8'd0) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
